samp_sequencer: RTL and testbench

- Consumes the 8-bit sampling control byte driven by the CPU-written sample-control PIO.
- Turns that byte into timed ADC conversion/read cycles over a channel scan, and buffers each result in a small show-ahead FIFO.
- The FIFO feeds a valid/ready stream to the downstream sample store.
- Sits between the control PIO and the external parallel ADC / sample memory path; single clock domain.

---
 rtl/samp_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_samp_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/samp_sequencer.sv
// samp_sequencer: turns the PIO sampling control byte into timed ADC
// convert/read cycles over a channel scan and buffers each result in a
// show-ahead FIFO that feeds a valid/ready stream to the sample store.
//
// Optional feature macro: SAMP_TIMESTAMP_EN
//   When defined, a 16-bit free-running timestamp is captured at the start
//   of each channel conversion, stored with the sample and presented on smp_ts.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   ctrl[7:0]         {rate_sel[2:0], last_chan[2:0], cont, run}
//   adc_busy          ADC conversion in progress
//   adc_data          ADC parallel data bus
//   adc_convst_n      conversion start strobe (active-low)
//   adc_rd_n          ADC read strobe (active-low)
//   adc_chan          ADC input mux select
//   smp_data/chan     head-of-FIFO sample and its channel
//   smp_valid         FIFO non-empty
//   smp_ready         downstream accepts the head sample
//   seq_busy          sequencer not idle
//   overrun           sticky: a sample was dropped on a full FIFO
//   timeout_err       sticky: busy did not fall within CONV_TIMEOUT clocks
//   smp_ts            (SAMP_TIMESTAMP_EN only) timestamp of head sample
`timescale 1ns/1ps

module samp_sequencer #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CLK_DIV_BASE = 50,
  parameter int unsigned CONV_TIMEOUT = 255,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        ctrl,
  input  logic              adc_busy,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_convst_n,
  output logic              adc_rd_n,
  output logic [2:0]        adc_chan,
  output logic [DATA_W-1:0] smp_data,
  output logic [2:0]        smp_chan,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              seq_busy,
  output logic              overrun,
  output logic              timeout_err
`ifdef SAMP_TIMESTAMP_EN
  ,
  output logic [15:0]       smp_ts
`endif
);

  localparam int unsigned DIV_W = $clog2(8 * CLK_DIV_BASE);
  localparam int unsigned TO_W  = $clog2(CONV_TIMEOUT + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TS_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_CONVST, S_WAIT_BUSY, S_READ, S_PUSH, S_NEXT
  } state_t;

  typedef struct packed {
`ifdef SAMP_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [2:0]        chan;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Control byte fields
  logic       run, cont;
  logic [2:0] last_chan, rate_sel;
  assign run       = ctrl[0];
  assign cont      = ctrl[1];
  assign last_chan = ctrl[4:2];
  assign rate_sel  = ctrl[7:5];

  logic run_q;
  logic run_rise_c;
  assign run_rise_c = run & ~run_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= run;
  end

  // Rate divider; the period is re-sampled from rate_sel at run start and
  // at every terminal count.
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       rate_q;
  logic [DIV_W-1:0] div_term_c;
  logic             tick_c;

  assign div_term_c = DIV_W'((32'(rate_q) + 32'd1) * CLK_DIV_BASE - 32'd1);
  assign tick_c     = run & run_q & (div_cnt == div_term_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      rate_q  <= '0;
    end else if (!run) begin
      div_cnt <= '0;
    end else if (!run_q) begin
      div_cnt <= div_cnt + DIV_W'(1);
      rate_q  <= rate_sel;
    end else if (div_cnt == div_term_c) begin
      div_cnt <= '0;
      rate_q  <= rate_sel;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // FIFO status used by the sequencer
  logic [CNT_W-1:0] fcnt;
  logic             full_c, pop_c, push_c, wr_en_c;
  assign full_c  = (fcnt == CNT_W'(FIFO_DEPTH));
  assign pop_c   = smp_valid & smp_ready;
  assign wr_en_c = push_c & (~full_c | pop_c);

  // Sequencer state
  state_t           state, state_d;
  logic [TO_W-1:0]  cnt, cnt_d;
  logic [2:0]       chan, chan_d;
  logic             flag_clr_c, timeout_set_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      chan  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      chan  <= chan_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    chan_d        = chan;
    push_c        = 1'b0;
    flag_clr_c    = 1'b0;
    timeout_set_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_rise_c) begin
          state_d    = S_WAIT_TICK;
          chan_d     = '0;
          cnt_d      = '0;
          flag_clr_c = 1'b1;
        end
      end
      S_WAIT_TICK: begin
        if (tick_c) begin
          state_d = S_CONVST;
          cnt_d   = '0;
        end
      end
      S_CONVST: begin
        if (cnt == TO_W'(1)) begin
          state_d = S_WAIT_BUSY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
      end
      S_WAIT_BUSY: begin
        // busy is not trusted for the first two clocks after convst release
        if ((cnt >= TO_W'(2)) && !adc_busy) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt == TO_W'(CONV_TIMEOUT - 1)) begin
          state_d       = S_NEXT;
          cnt_d         = '0;
          timeout_set_c = 1'b1;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
      end
      S_READ: begin
        if (cnt == TO_W'(1)) begin
          state_d = S_PUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
      end
      S_PUSH: begin
        push_c  = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (chan < last_chan) begin
          chan_d  = chan + 3'd1;
          state_d = S_CONVST;
        end else begin
          chan_d  = '0;
          state_d = cont ? S_WAIT_TICK : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping run abandons whatever is in flight
    if ((state != S_IDLE) && !run) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      push_c        = 1'b0;
      timeout_set_c = 1'b0;
    end
  end

  // Registered ADC strobes and status, driven from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_convst_n <= 1'b1;
      adc_rd_n     <= 1'b1;
      adc_chan     <= '0;
      seq_busy     <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      adc_convst_n <= (state_d != S_CONVST);
      adc_rd_n     <= (state_d != S_READ);
      seq_busy     <= (state_d != S_IDLE);
      if ((state_d == S_CONVST) && (state != S_CONVST)) adc_chan <= chan_d;
      if (flag_clr_c) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (push_c && full_c && !pop_c) overrun <= 1'b1;
        if (timeout_set_c)              timeout_err <= 1'b1;
      end
    end
  end

  // Sample capture at the edge ending the second read-low cycle
  logic [DATA_W-1:0] data_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              data_q <= '0;
    else if ((state == S_READ) && (cnt == TO_W'(1))) data_q <= adc_data;
  end

`ifdef SAMP_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt, ts_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if ((state == S_CONVST) && (cnt == '0)) ts_q <= ts_cnt;
    end
  end
`endif

  entry_t wr_entry_c;
  always_comb begin
    wr_entry_c      = '0;
    wr_entry_c.chan = chan;
    wr_entry_c.data = data_q;
`ifdef SAMP_TIMESTAMP_EN
    wr_entry_c.ts   = ts_q;
`endif
  end

  // Show-ahead sample FIFO
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fcnt_d;

  always_comb begin
    fcnt_d = fcnt;
    if (wr_en_c && !pop_c)      fcnt_d = fcnt + CNT_W'(1);
    else if (!wr_en_c && pop_c) fcnt_d = fcnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fcnt      <= '0;
      smp_valid <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= wr_entry_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      fcnt      <= fcnt_d;
      smp_valid <= (fcnt_d != '0);
    end
  end

  entry_t head;
  assign head     = mem[rd_ptr];
  assign smp_data = head.data;
  assign smp_chan = head.chan;
`ifdef SAMP_TIMESTAMP_EN
  assign smp_ts   = head.ts;
`endif

endmodule

// File: tb/tb_samp_sequencer.sv
// Self-checking bench for samp_sequencer: a scoreboard queue holds the
// expected {chan, data} samples and a monitor compares each FIFO pop.
`timescale 1ns/1ps

module tb_samp_sequencer;

  localparam int SIG_CONVST  = 0;
  localparam int SIG_RD      = 1;
  localparam int SIG_BUSY    = 2;
  localparam int SIG_TIMEOUT = 3;
  localparam int SIG_OVERRUN = 4;

  logic        clk;
  logic        reset_n;
  logic [7:0]  ctrl;
  logic        adc_busy;
  logic [15:0] adc_data;
  logic        adc_convst_n, adc_rd_n;
  logic [2:0]  adc_chan;
  logic [15:0] smp_data;
  logic [2:0]  smp_chan;
  logic        smp_valid, smp_ready;
  logic        seq_busy, overrun, timeout_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  logic [18:0] exp_q [$];
  logic [18:0] mon_exp;
  logic [15:0] data_ofs;
  logic        stuck;
  int          busy_cnt = 0;

  samp_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl         (ctrl),
    .adc_busy     (adc_busy),
    .adc_data     (adc_data),
    .adc_convst_n (adc_convst_n),
    .adc_rd_n     (adc_rd_n),
    .adc_chan     (adc_chan),
    .smp_data     (smp_data),
    .smp_chan     (smp_chan),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .seq_busy     (seq_busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: busy while convst is low and for 5 clocks after release
  always @(posedge clk) begin
    if (!adc_convst_n)    busy_cnt <= 5;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign adc_busy = stuck | (busy_cnt != 0);
  assign adc_data = 16'(32'h1111 * (32'(adc_chan) + 32'd1) + 32'(data_ofs));

  function automatic logic [18:0] exp_entry(input int ch, input logic [15:0] ofs);
    return {3'(ch), 16'(32'h1111 * (32'(ch) + 32'd1) + 32'(ofs))};
  endfunction

  // Scoreboard monitor: every accepted head sample must match the queue
  always @(negedge clk) begin
    if (reset_n && smp_valid && smp_ready) begin
      pops++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got chan %0d data %h, none expected", smp_chan, smp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({smp_chan, smp_data} !== mon_exp) begin
          miscompares++;
          $display("FAIL pop_data: got chan %0d data %h, want chan %0d data %h",
                   smp_chan, smp_data, mon_exp[18:16], mon_exp[15:0]);
        end
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      SIG_CONVST:  return adc_convst_n;
      SIG_RD:      return adc_rd_n;
      SIG_BUSY:    return seq_busy;
      SIG_TIMEOUT: return timeout_err;
      default:     return overrun;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Bounded wait; n = clock edges consumed
  task automatic wait_sig(input int which, input logic val, input int max_cyc,
                          output int n, output bit ok);
    n = 0;
    while (sig(which) !== val && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (sig(which) === val);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ctrl = 8'h00; smp_ready = 1'b0; stuck = 1'b0; data_ofs = 16'h0000;
    step(3);
    vectors++; if (adc_convst_n !== 1'b1) begin miscompares++; $display("FAIL reset_convst_n: got %b want 1", adc_convst_n); end
    vectors++; if (adc_rd_n !== 1'b1) begin miscompares++; $display("FAIL reset_rd_n: got %b want 1", adc_rd_n); end
    vectors++; if (adc_chan !== 3'd0) begin miscompares++; $display("FAIL reset_adc_chan: got %0d want 0", adc_chan); end
    vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL reset_seq_busy: got %b want 0", seq_busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    vectors++; if (smp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_smp_valid: got %b want 0", smp_valid); end
    vectors++; if ({smp_chan, smp_data} !== 19'd0) begin miscompares++; $display("FAIL reset_head: got %h want 0", {smp_chan, smp_data}); end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_scan();
    int n; bit ok;
    data_ofs = 16'h0000;
    for (int c = 0; c < 3; c++) exp_q.push_back(exp_entry(c, data_ofs));
    ctrl = 8'h09;
    wait_sig(SIG_CONVST, 1'b0, 200, n, ok);
    vectors++; if (!ok || n != 50) begin miscompares++; $display("FAIL single_first_convst: got %0d clocks want 50", n); end
    wait_sig(SIG_BUSY, 1'b0, 1000, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_done: seq_busy still %b want 0", seq_busy); end
    vectors++; if (smp_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", smp_valid); end
    smp_ready = 1'b1;
    step(10);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_drain: %0d left want 0", exp_q.size()); end
    vectors++; if (smp_valid !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %b want 0", smp_valid); end
    ctrl = 8'h00;
    step(2);
  endtask

  task automatic test_continuous();
    int n, n2; bit ok;
    smp_ready = 1'b1;
    data_ofs = 16'h0010;
    exp_q.push_back(exp_entry(0, data_ofs));
    ctrl = 8'h23;
    wait_sig(SIG_CONVST, 1'b0, 300, n, ok);
    vectors++; if (!ok || n != 100) begin miscompares++; $display("FAIL cont_first_convst: got %0d clocks want 100", n); end
    for (int i = 1; i < 4; i++) begin
      wait_sig(SIG_CONVST, 1'b1, 10, n, ok);
      wait_sig(SIG_CONVST, 1'b0, 300, n2, ok);
      data_ofs = 16'(16'h0010 + 16'(i));
      exp_q.push_back(exp_entry(0, data_ofs));
      vectors++; if (!ok || (n + n2) != 100) begin miscompares++; $display("FAIL cont_period: got %0d clocks want 100", n + n2); end
    end
    wait_sig(SIG_CONVST, 1'b1, 10, n, ok);
    step(30);
    ctrl = 8'h00;
    step(5);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL cont_overrun: got %b want 0", overrun); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL cont_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    int n; bit ok;
    smp_ready = 1'b0;
    data_ofs = 16'h0100;
    for (int c = 0; c < 8; c++) exp_q.push_back(exp_entry(c, data_ofs));
    ctrl = 8'h1F;
    wait_sig(SIG_OVERRUN, 1'b1, 2000, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovr_set: got %b want 1", overrun); end
    vectors++; if ({smp_chan, smp_data} !== exp_entry(0, 16'h0100)) begin miscompares++; $display("FAIL ovr_head: got %h want %h", {smp_chan, smp_data}, exp_entry(0, 16'h0100)); end
    ctrl = 8'h00;
    step(3);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    smp_ready = 1'b1;
    step(20);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ovr_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int n; bit ok;
    smp_ready = 1'b1;
    stuck = 1'b1;
    data_ofs = 16'h0200;
    exp_q.push_back(exp_entry(1, data_ofs));
    ctrl = 8'h05;
    step(1);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL to_ovr_clear: got %b want 0", overrun); end
    wait_sig(SIG_CONVST, 1'b0, 100, n, ok);
    wait_sig(SIG_CONVST, 1'b1, 10, n, ok);
    wait_sig(SIG_TIMEOUT, 1'b1, 400, n, ok);
    vectors++; if (!ok || n != 255) begin miscompares++; $display("FAIL to_latency: got %0d clocks want 255", n); end
    stuck = 1'b0;
    wait_sig(SIG_BUSY, 1'b0, 200, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_done: seq_busy %b want 0", seq_busy); end
    step(3);
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL to_drain: %0d left want 0", exp_q.size()); end
    ctrl = 8'h00;
    step(2);
  endtask

  task automatic test_abort();
    int n; bit ok;
    smp_ready = 1'b1;
    ctrl = 8'h01;
    step(1);
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL abort_clear: timeout_err %b want 0", timeout_err); end
    wait_sig(SIG_RD, 1'b0, 200, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL abort_rd_wait: rd_n %b want 0", adc_rd_n); end
    ctrl = 8'h00;
    step(1);
    vectors++; if (adc_rd_n !== 1'b1) begin miscompares++; $display("FAIL abort_rd_n: got %b want 1", adc_rd_n); end
    vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: seq_busy %b want 0", seq_busy); end
    step(10);
    vectors++; if (smp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_push: smp_valid %b want 0", smp_valid); end
  endtask

  task automatic test_full_push_pop();
    int n, p0; bit ok;
    p0 = pops;
    smp_ready = 1'b0;
    data_ofs = 16'h0300;
    for (int c = 0; c < 8; c++) exp_q.push_back(exp_entry(c, data_ofs));
    ctrl = 8'h1D;
    step(1);
    wait_sig(SIG_BUSY, 1'b0, 2000, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL full_fill: seq_busy %b want 0", seq_busy); end
    ctrl = 8'h00;
    step(2);
    data_ofs = 16'h0400;
    exp_q.push_back(exp_entry(0, data_ofs));
    ctrl = 8'h01;
    wait_sig(SIG_RD, 1'b0, 200, n, ok);
    wait_sig(SIG_RD, 1'b1, 5, n, ok);
    smp_ready = 1'b1;
    step(1);
    smp_ready = 1'b0;
    step(2);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL full_overrun: got %b want 0", overrun); end
    ctrl = 8'h00;
    smp_ready = 1'b1;
    step(20);
    vectors++; if ((pops - p0) != 9) begin miscompares++; $display("FAIL full_pops: got %0d want 9", pops - p0); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL full_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_continuous();
    test_overrun();
    test_timeout();
    test_abort();
    test_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
